deserializer_ctrl: RTL and testbench
====================================

DESERIALIZER_CTRL -- requirements
Module: deserializer_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the bits per assembled word, minimum 2.
REQ-002 Parameter CW, default $clog2(WIDTH+1), is the width of bit_count.
REQ-003 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  is the synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 in_bit  input  1  carries the serial data bit.
REQ-006 in_valid  input  1  means in_bit is offered this cycle.
REQ-007 in_ready  output  1  means the block accepts in_bit this cycle.
REQ-008 frame_start  input  1  resynchronises the word boundary.
REQ-009 out_data  output  WIDTH  carries the assembled parallel word.
REQ-010 out_valid  output  1  means out_data holds a complete word.
REQ-011 out_ready  input  1  means the consumer takes out_data this cycle.
REQ-012 bit_count  output  CW  is the number of bits collected toward the current word, 0..WIDTH-1.

Function
REQ-013 Bit acceptance SHALL occur only on a cycle with in_valid=1 and in_ready=1 (a "shift").
REQ-014 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-015 On each shift, the datapath SHALL shift right, with in_bit entering out_data[WIDTH-1].
REQ-016 The first-received bit of a word SHALL reside in out_data[0] when the word completes.
REQ-017 The state machine SHALL have states COLLECT (out_valid=0) and HOLD (out_valid=1).
REQ-018 In COLLECT, a shift SHALL increment bit_count.
REQ-019 In COLLECT, a shift with bit_count=WIDTH-1 SHALL set bit_count=0 and enter HOLD next cycle, so out_valid rises one cycle after the WIDTH-th shift.
REQ-020 In HOLD, out_data SHALL remain stable until the cycle out_valid=1 and out_ready=1.
REQ-021 In HOLD, if out_ready=1 and no shift occurs, the block SHALL return to COLLECT with bit_count=0.
REQ-022 In HOLD, if out_ready=1 and a shift occurs in the same cycle, the word SHALL be consumed, the new bit accepted, bit_count SHALL become 1, and the state SHALL be COLLECT.
REQ-023 In HOLD, if out_ready=0, in_ready SHALL be 0 and no bit is lost or accepted.
REQ-024 frame_start=1 with a shift SHALL make that bit bit 0 of a new word (bit_count becomes 1), discarding any partial word.
REQ-025 frame_start=1 without a shift in COLLECT SHALL set bit_count=0.
REQ-026 frame_start SHALL never discard a word in HOLD.
REQ-027 If WIDTH=... only shift count defines completion; stale register contents SHALL be fully overwritten after WIDTH shifts.

Reset
REQ-028 Reset SHALL force state COLLECT, bit_count=0, out_valid=0, and out_data all zeros on the next rising edge.
REQ-029 Reset SHALL take priority over all inputs, including mid-word and in HOLD (the held word is discarded).
REQ-030 in_ready SHALL be 1 in the first cycle after reset deassertion.

Structure
REQ-031 The datapath SHALL be one instance of the existing right_shift_register_base, generalised to WIDTH and wired as (in_bit, clk, shift, reset, out_data); it is the only sub-module.
REQ-032 The state encoding and the CW derivation SHALL live in a shared package, deser_pkg.
REQ-033 The controller SHALL own only the FSM, the bit counter and the handshake logic.

Verification
REQ-034 After reset, shift bits 0,1,1,0,1,0,1,1 with out_ready=0 -> out_valid=1 on the cycle after the 8th bit; out_data=8'b11010110; in_ready=0.
REQ-035 Hold out_valid=1 for 5 cycles with out_ready=0 and in_valid=1 -> out_data unchanged, bit_count=0, no bits accepted.
REQ-036 Assert out_ready with in_valid=1 and in_bit=1 while in HOLD -> word consumed, bit_count=1, out_valid=0 next cycle; complete 7 more bits of 1 -> out_data=8'hFF.
REQ-037 Shift 3 bits, then frame_start=1 with in_bit=1, then 7 zero bits -> out_data=8'b00000001.
REQ-038 Shift 5 bits, then assert reset for 1 cycle -> bit_count=0, out_data=0, out_valid=0; the next 8 bits form a complete word.
REQ-039 Stream 16 back-to-back bits with in_valid=1 and out_ready=1 constantly -> two words delivered with no bit dropped, and in_ready=1 throughout.

Source files
------------

// File: rtl/deser_pkg.sv
// Purpose : shared definitions for the serial-to-parallel deserializer.
// Latency : n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: FSM state encoding (COLLECT/HOLD) and the bit-counter width helper.
package deser_pkg;

    // Controller states; out_valid is simply "state == HOLD".
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] HOLD    = 1'b1;

    // Counter width able to represent 0..width.
    function automatic int deser_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/right_shift_register_base.sv
// Purpose : WIDTH-bit right shift register; the new bit enters at the MSB.
// Latency : out_data reflects a shift one cycle after the shift is sampled.
// Backpressure: none; holds its contents whenever shift=0.
// Ports   : in_bit (serial in), clk, shift (enable), reset (sync, active-high),
//           out_data (parallel contents, first-shifted bit ends up at bit 0).
module right_shift_register_base #(
    parameter int WIDTH = 8
) (
    input  logic             in_bit,
    input  logic             clk,
    input  logic             shift,
    input  logic             reset,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (shift) begin
            r_data <= {in_bit, r_data[WIDTH-1:1]};
        end
    end

    assign out_data = r_data;

endmodule

// File: rtl/deserializer_ctrl.sv
// Purpose : assembles a serial bit stream into WIDTH-bit words with valid/ready on both sides.
// Latency : out_valid rises one cycle after the WIDTH-th accepted bit.
// Backpressure: in_ready = !out_valid || out_ready; a held word stalls input until consumed.
// Ports   : clk, reset (sync, active-high); in_bit/in_valid/in_ready serial side;
//           frame_start word resync; out_data/out_valid/out_ready parallel side;
//           bit_count bits collected toward the current word.
module deserializer_ctrl
    import deser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = deser_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             frame_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    bit_count
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [0:0]    r_state;
    logic [CW-1:0] r_bit_count;
    logic          w_shift;

    assign out_valid = (r_state == HOLD);
    assign in_ready  = !out_valid || out_ready;
    assign w_shift   = in_valid && in_ready;
    assign bit_count = r_bit_count;

    // Datapath: the shift register needs no knowledge of word boundaries;
    // completion is decided purely by the counter below, so stale bits left
    // by a frame_start resync are pushed out by the next WIDTH shifts.
    right_shift_register_base #(
        .WIDTH (WIDTH)
    ) u_sreg (
        .in_bit   (in_bit),
        .clk      (clk),
        .shift    (w_shift),
        .reset    (reset),
        .out_data (out_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= COLLECT;
            r_bit_count <= '0;
        end else if (r_state == COLLECT) begin
            if (w_shift) begin
                if (frame_start) begin
                    // This bit starts a fresh word; the partial word is dropped.
                    r_bit_count <= CNT_ONE;
                end else if (r_bit_count == CNT_LAST) begin
                    r_bit_count <= '0;
                    r_state     <= HOLD;
                end else begin
                    r_bit_count <= r_bit_count + CNT_ONE;
                end
            end else if (frame_start) begin
                r_bit_count <= '0;
            end
        end else begin
            // HOLD: frame_start is ignored so a finished word is never lost.
            // A shift here can only happen when out_ready=1, i.e. the word is
            // consumed and the incoming bit becomes bit 0 of the next word.
            if (out_ready) begin
                r_state     <= COLLECT;
                r_bit_count <= w_shift ? CNT_ONE : '0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer_ctrl.sv
module tb_deserializer_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          in_bit;
    logic          in_valid;
    logic          in_ready;
    logic          frame_start;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] bit_count;

    deserializer_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_bit      (in_bit),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .frame_start (frame_start),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bit_count   (bit_count)
    );

    always #5 clk = ~clk;

    // Reference model: the bits of the word in progress kept as a queue
    // (index 0 = first received), plus the completed word while held.
    bit           m_hold;
    bit           m_q[$];
    logic [W-1:0] m_word;

    // Words observed leaving the block (out_valid && out_ready at a clock edge).
    logic [W-1:0] deliv[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_step(input bit rst, input bit v, input bit b, input bit fs, input bit ordy);
        bit acc;
        acc = v && (!m_hold || ordy);
        if (rst) begin
            m_hold = 1'b0;
            m_q.delete();
            m_word = '0;
        end else if (m_hold) begin
            if (ordy) begin
                m_hold = 1'b0;
                m_q.delete();
                if (acc) m_q.push_back(b);
            end
        end else if (acc) begin
            if (fs) m_q.delete();
            m_q.push_back(b);
            if (m_q.size() == W) begin
                for (int i = 0; i < W; i++) m_word[i] = m_q[i];
                m_hold = 1'b1;
                m_q.delete();
            end
        end else if (fs) begin
            m_q.delete();
        end
    endtask

    // One clock cycle: drive inputs, check the combinational ready, clock,
    // advance the model, then check the registered outputs.
    task automatic cyc(input bit rst, input bit v, input bit b, input bit fs, input bit ordy);
        reset       = rst;
        in_valid    = v;
        in_bit      = b;
        frame_start = fs;
        out_ready   = ordy;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_hold || ordy)});
        if (out_valid === 1'b1 && ordy && !rst) deliv.push_back(out_data);
        @(posedge clk);
        model_step(rst, v, b, fs, ordy);
        @(negedge clk);
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_hold});
        chk("bit_count", 32'(bit_count), m_hold ? 32'd0 : 32'(m_q.size()));
        if (m_hold) chk("out_data", 32'(out_data), 32'(m_word));
    endtask

    function automatic bit rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    initial begin
        logic [W-1:0] vec;
        logic [15:0]  s16;
        bit           rb;

        reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
        m_hold = 1'b0; m_word = '0;
        @(negedge clk);

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset bit_count", 32'(bit_count), 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        chk("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // Eight bits with consumer stalled
        vec = 8'b1101_0110;
        for (int i = 0; i < W; i++) cyc(0, 1, vec[i], 0, 0);
        chk("word1 data", 32'(out_data), 32'hD6);
        chk("word1 valid", {31'd0, out_valid}, 32'd1);
        chk("word1 in_ready stalled", {31'd0, in_ready}, 32'd0);

        // Stall with input pending: nothing accepted, word stable
        for (int i = 0; i < 5; i++) cyc(0, 1, rbit(), i == 2, 0);
        chk("stall data", 32'(out_data), 32'hD6);
        chk("stall bit_count", 32'(bit_count), 32'd0);

        // Consume and accept simultaneously, then seven more ones
        cyc(0, 1, 1, 0, 1);
        chk("consume+shift count", 32'(bit_count), 32'd1);
        chk("consume+shift valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0);
        chk("all ones word", 32'(out_data), 32'hFF);
        cyc(0, 0, 0, 0, 1);

        // frame_start resync discards a partial word
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 1);
        cyc(0, 1, 1, 1, 1);
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
        chk("resync word", 32'(out_data), 32'h01);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-word, then a full word
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("midword reset count", 32'(bit_count), 32'd0);
        chk("midword reset data", 32'(out_data), 32'd0);
        chk("midword reset valid", {31'd0, out_valid}, 32'd0);
        vec = 8'($urandom);
        for (int i = 0; i < W; i++) cyc(0, 1, vec[i], 0, 0);
        chk("post-reset word", 32'(out_data), 32'(vec));

        // Reset while holding a word
        cyc(1, 1, 0, 0, 0);
        chk("hold reset valid", {31'd0, out_valid}, 32'd0);
        chk("hold reset data", 32'(out_data), 32'd0);

        // Sixteen back-to-back bits, consumer always ready
        deliv.delete();
        s16 = 16'($urandom);
        for (int i = 0; i < 16; i++) cyc(0, 1, s16[i], 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("stream word count", 32'(deliv.size()), 32'd2);
        if (deliv.size() == 2) begin
            chk("stream word0", 32'(deliv[0]), 32'(s16[7:0]));
            chk("stream word1", 32'(deliv[1]), 32'(s16[15:8]));
        end

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            rb = rbit();
            cyc($urandom_range(59, 0) == 0, $urandom_range(3, 0) != 0, rb,
                $urandom_range(11, 0) == 0, $urandom_range(2, 0) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
